// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single main-memory port between the instruction-cache miss
//   path (I side) and the data-cache miss / write-back path (D side).  One
//   requester is granted at a time; its address, write enable and write line
//   are captured at grant, a single memory transaction is run, and the
//   returned line is handed back with a one-cycle done pulse.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : a tie between reqI and reqD goes to the side opposite the
//                 previous grant (previous grant resets to D, so the first
//                 tie goes to I)
//     undefined : fixed priority, D wins every tie
//
//   Ports
//     clock, reset_n        rising-edge clock, asynchronous active-low reset
//     reqI, reqAddrI        I-side request (level) and line address
//     doneI, rdataI         I-side completion pulse and returned line
//     reqD, reqAddrD        D-side request (level) and line address
//     weD, wdataD           D-side write-back flag and write-back line
//     doneD, rdataD         D-side completion pulse and returned line
//     mem_req, mem_we       memory request (held until mem_ack), write enable
//     mem_addr, mem_wdata   memory line address and write line
//     mem_ack, mem_rdata    memory completion pulse and read line
//     busy                  high whenever the arbiter is not idle

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              reqI,
  input  logic [ADDR_W-1:0] reqAddrI,
  output logic              doneI,
  output logic [LINE_W-1:0] rdataI,
  input  logic              reqD,
  input  logic [ADDR_W-1:0] reqAddrD,
  input  logic              weD,
  input  logic [LINE_W-1:0] wdataD,
  output logic              doneD,
  output logic [LINE_W-1:0] rdataD,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT_I  = 3'd1,
    GRANT_D  = 3'd2,
    WAIT_MEM = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t            state, state_next;

  // Captured transaction: granted side (1 = D), address, write enable, line
  logic              lat_side, lat_side_next;
  logic [ADDR_W-1:0] lat_addr, lat_addr_next;
  logic              lat_we, lat_we_next;
  logic [LINE_W-1:0] lat_wdata, lat_wdata_next;

  // Side that received the most recent grant (1 = D)
  logic              last_grant, last_grant_next;

  logic              grant_d;

  logic              doneI_next, doneD_next;
  logic [LINE_W-1:0] rdataI_next, rdataD_next;
  logic              mem_req_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [LINE_W-1:0] mem_wdata_next;
  logic              busy_next;

  // Tie-break between the two request lines while idle.
`ifdef ARB_ROUND_ROBIN_EN
  assign grant_d = reqD && (!reqI || !last_grant);
`else
  assign grant_d = reqD;
`endif

  // State and every output are registered together so that all outputs
  // change only on the clock edge and all clear together on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_side   <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      last_grant <= 1'b1;
      doneI      <= 1'b0;
      doneD      <= 1'b0;
      rdataI     <= '0;
      rdataD     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      lat_side   <= lat_side_next;
      lat_addr   <= lat_addr_next;
      lat_we     <= lat_we_next;
      lat_wdata  <= lat_wdata_next;
      last_grant <= last_grant_next;
      doneI      <= doneI_next;
      doneD      <= doneD_next;
      rdataI     <= rdataI_next;
      rdataD     <= rdataD_next;
      mem_req    <= mem_req_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      busy       <= busy_next;
    end
  end

  // Next-state and next-output logic.  Done pulses default low so they last
  // exactly the one RESP cycle; everything else holds unless changed.
  always_comb begin
    state_next      = state;
    lat_side_next   = lat_side;
    lat_addr_next   = lat_addr;
    lat_we_next     = lat_we;
    lat_wdata_next  = lat_wdata;
    last_grant_next = last_grant;
    doneI_next      = 1'b0;
    doneD_next      = 1'b0;
    rdataI_next     = rdataI;
    rdataD_next     = rdataD;
    mem_req_next    = mem_req;
    mem_we_next     = mem_we;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;

    case (state)
      IDLE: begin
        if (reqI || reqD) begin
          lat_side_next   = grant_d;
          last_grant_next = grant_d;
          lat_addr_next   = grant_d ? reqAddrD : reqAddrI;
          lat_we_next     = grant_d && weD;
          lat_wdata_next  = grant_d ? wdataD : '0;
          state_next      = grant_d ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        mem_req_next   = 1'b1;
        mem_addr_next  = lat_addr;
        mem_we_next    = lat_we;
        mem_wdata_next = lat_wdata;
        state_next     = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (lat_side) begin
            rdataD_next = mem_rdata;
            doneD_next  = 1'b1;
          end else begin
            rdataI_next = mem_rdata;
            doneI_next  = 1'b1;
          end
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter.  Directed cases followed by random
//   request patterns; expected grant order, addresses and returned lines come
//   from a small arbitration model kept here.

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clock;
  logic          reset_n;
  logic          reqI;
  logic [AW-1:0] reqAddrI;
  logic          doneI;
  logic [LW-1:0] rdataI;
  logic          reqD;
  logic [AW-1:0] reqAddrD;
  logic          weD;
  logic [LW-1:0] wdataD;
  logic          doneD;
  logic [LW-1:0] rdataD;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic          busy;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  bit            lastGrantD = 1'b1;
  logic [LW-1:0] expRdataI  = '0;
  logic [LW-1:0] expRdataD  = '0;
  bit            rdataDKnown = 1'b1;
  logic [AW-1:0] addrIExp, addrDExp;
  bit            weDExp;
  logic [LW-1:0] wdataDExp;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .reqI      (reqI),
    .reqAddrI  (reqAddrI),
    .doneI     (doneI),
    .rdataI    (rdataI),
    .reqD      (reqD),
    .reqAddrD  (reqAddrD),
    .weD       (weD),
    .wdataD    (wdataD),
    .doneD     (doneD),
    .rdataD    (rdataD),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [LW-1:0] randLine();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Which side wins when the arbiter sees the given request lines in IDLE.
  function automatic bit pickD(bit wantI, bit wantD);
    if (wantI && wantD) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !lastGrantD;
`else
      return 1'b1;
`endif
    end
    return wantD;
  endfunction

  task automatic checkOutput(string tag, logic [LW-1:0] observed, logic [LW-1:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, ".doneI"},     LW'(doneI),     '0);
    checkOutput({tag, ".doneD"},     LW'(doneD),     '0);
    checkOutput({tag, ".rdataI"},    rdataI,         '0);
    checkOutput({tag, ".rdataD"},    rdataD,         '0);
    checkOutput({tag, ".mem_req"},   LW'(mem_req),   '0);
    checkOutput({tag, ".mem_we"},    LW'(mem_we),    '0);
    checkOutput({tag, ".mem_addr"},  LW'(mem_addr),  '0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata,      '0);
    checkOutput({tag, ".busy"},      LW'(busy),      '0);
  endtask

  // Acts as memory and requester for one transaction of the given side,
  // starting from the negedge where the arbiter is idle.
  task automatic serve(bit sideD, int ackDelay);
    int            cnt;
    logic [LW-1:0] rd;
    logic [AW-1:0] expAddr;
    bit            expWe;
    expAddr = sideD ? addrDExp : addrIExp;
    expWe   = sideD && weDExp;
    lastGrantD = sideD;
    cnt = 0;
    while (cnt < 12) begin
      @(negedge clock);
      cnt++;
      if (mem_req) break;
    end
    checkOutput("grantLatency", LW'(cnt), LW'(2));
    if (!mem_req) begin
      reqI = 1'b0;
      reqD = 1'b0;
      repeat (6) @(negedge clock);
      return;
    end
    checkOutput("memAddr", LW'(mem_addr), LW'(expAddr));
    checkOutput("memWe",   LW'(mem_we),   LW'(expWe));
    if (expWe) checkOutput("memWdata", mem_wdata, wdataDExp);
    for (int k = 0; k < ackDelay; k++) begin
      // Captured values must survive changes on the granted side's inputs
      if (sideD) begin
        reqAddrD = $urandom();
        wdataD   = randLine();
      end else begin
        reqAddrI = $urandom();
      end
      @(negedge clock);
      checkOutput("memReqHeld",  LW'(mem_req),  LW'(1));
      checkOutput("memAddrHeld", LW'(mem_addr), LW'(expAddr));
      checkOutput("waitNoDone",  LW'({doneI, doneD}), LW'(0));
    end
    rd        = randLine();
    mem_rdata = rd;
    mem_ack   = 1'b1;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = randLine();
    checkOutput("doneGranted", LW'(sideD ? doneD : doneI), LW'(1));
    checkOutput("doneOther",   LW'(sideD ? doneI : doneD), LW'(0));
    checkOutput("respMemReq",  LW'(mem_req), LW'(0));
    checkOutput("respBusy",    LW'(busy),    LW'(1));
    if (sideD) begin
      if (expWe) begin
        rdataDKnown = 1'b0;
      end else begin
        rdataDKnown = 1'b1;
        expRdataD   = rd;
      end
      reqD = 1'b0;
    end else begin
      expRdataI = rd;
      reqI = 1'b0;
    end
    if (!expWe) checkOutput("rdataReturned", sideD ? rdataD : rdataI, rd);
    @(negedge clock);
    checkOutput("doneOnePulse", LW'({doneI, doneD}), LW'(0));
    checkOutput("idleBusy",     LW'(busy), LW'(0));
    checkOutput("rdataIHold",   rdataI, expRdataI);
    if (rdataDKnown) checkOutput("rdataDHold", rdataD, expRdataD);
  endtask

  // Raises the requested lines together at an idle negedge and serves them
  // in the order the model predicts.
  task automatic applyStimulus(bit wantI, bit wantD, logic [AW-1:0] aI, logic [AW-1:0] aD,
                               bit we, logic [LW-1:0] wd, int delay1, int delay2);
    bit first;
    addrIExp  = aI;
    addrDExp  = aD;
    weDExp    = we;
    wdataDExp = wd;
    reqAddrI  = aI;
    reqAddrD  = aD;
    weD       = we;
    wdataD    = wd;
    reqI      = wantI;
    reqD      = wantD;
    first = pickD(wantI, wantD);
    serve(first, delay1);
    if (wantI && wantD) serve(!first, delay2);
  endtask

  initial begin
    reset_n   = 1'b0;
    reqI      = 1'b0;
    reqD      = 1'b0;
    reqAddrI  = '0;
    reqAddrD  = '0;
    weD       = 1'b0;
    wdataD    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    #2;
    checkAllZero("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkAllZero("afterReset");

    // Tie straight out of reset
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0300, 1'b0, '0, 1, 2);
    // Second tie
    applyStimulus(1'b1, 1'b1, 32'h0000_0440, 32'h0000_0500, 1'b1, randLine(), 0, 0);

    // I fill with ack three cycles after mem_req; address scrambled while waiting
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0, '0, 3, 0);

    // D write-back of an A5 pattern
    applyStimulus(1'b0, 1'b1, '0, 32'h0000_0100, 1'b1, {16{8'hA5}}, 1, 0);

    // D line fill with ack in the first wait cycle
    applyStimulus(1'b0, 1'b1, '0, 32'h0000_0200, 1'b0, '0, 0, 0);

    // mem_ack while idle must be ignored
    mem_rdata = randLine();
    mem_ack   = 1'b1;
    @(negedge clock);
    mem_ack   = 1'b0;
    checkOutput("idleAckBusy", LW'(busy), LW'(0));
    checkOutput("idleAckDone", LW'({doneI, doneD}), LW'(0));
    checkOutput("idleAckMemReq", LW'(mem_req), LW'(0));
    checkOutput("idleAckRdataI", rdataI, expRdataI);
    @(negedge clock);
    checkOutput("idleAckStill", LW'(busy), LW'(0));

    // Reset in the middle of a wait, then a late ack
    reqAddrI = 32'h0000_0040;
    reqI     = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("preResetMemReq", LW'(mem_req), LW'(1));
    reset_n = 1'b0;
    reqI    = 1'b0;
    #1;
    checkAllZero("midReset");
    lastGrantD  = 1'b1;
    expRdataI   = '0;
    expRdataD   = '0;
    rdataDKnown = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    mem_rdata = randLine();
    mem_ack   = 1'b1;
    @(negedge clock);
    mem_ack   = 1'b0;
    checkOutput("lateAckDone", LW'({doneI, doneD}), LW'(0));
    checkOutput("lateAckBusy", LW'(busy), LW'(0));
    @(negedge clock);
    checkAllZero("lateAckAfter");

    // Random request patterns
    for (int n = 0; n < 30; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      applyStimulus(pat[0], pat[1], $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                    randLine(), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
